countdown_timer: RTL and testbench



---
 rtl/countdown_timer.sv | 97 +++++++++
 tb/tb_countdown_timer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// Loadable N-bit down-counter with a one-cycle terminal-count pulse and optional auto-reload.
// Intended for tick generation: baud ticks, debounce windows and timeouts.
module countdown_timer #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         load,
  input  logic [N-1:0] load_value,
  input  logic         auto_reload,
  input  logic         stop,
  output logic [N-1:0] count,
  output logic         busy,
  output logic         done,
  output logic         expired
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRunning = 2'd1,
    StExpired = 2'd2
  } state_e;

  localparam logic [N-1:0] CountZero = '0;
  localparam logic [N-1:0] CountOne  = {{(N-1){1'b0}}, 1'b1};

  state_e       state_q, state_d;
  logic [N-1:0] count_q, count_d;
  logic [N-1:0] reload_q, reload_d;
  logic         done_q, done_d;

  logic         terminal;

  // Terminal event: the enabled decrement that would take the count from 1 to 0.
  assign terminal = (state_q == StRunning) && ena && (count_q == CountOne);

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = 1'b0;

    if (load) begin
      count_d  = load_value;
      reload_d = load_value;
      state_d  = (load_value != CountZero) ? StRunning : StIdle;
    end else if (stop) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StRunning: begin
          if (terminal) begin
            done_d = 1'b1;
            if (auto_reload) begin
              count_d = reload_q;
            end else begin
              count_d = CountZero;
              state_d = StExpired;
            end
          end else if (ena && (count_q != CountZero)) begin
            count_d = count_q - CountOne;
          end
        end
        StExpired: begin
          count_d = CountZero;
        end
        StIdle: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      count_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  assign count   = count_q;
  assign done    = done_q;
  assign busy    = (state_q == StRunning);
  assign expired = (state_q == StExpired);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer (N=8).
module tb_countdown_timer;

  logic       clk;
  logic       rst;
  logic       ena;
  logic       load;
  logic [7:0] load_value;
  logic       auto_reload;
  logic       stop;
  logic [7:0] count;
  logic       busy;
  logic       done;
  logic       expired;

  int total;
  int bad;

  countdown_timer #(.N(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .load       (load),
    .load_value (load_value),
    .auto_reload(auto_reload),
    .stop       (stop),
    .count      (count),
    .busy       (busy),
    .done       (done),
    .expired    (expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pulses;
    int n;
    logic [7:0] exp_cnt;

    total = 0;
    bad   = 0;
    rst = 1'b0; ena = 1'b0; load = 1'b1; load_value = 8'h55; auto_reload = 1'b0; stop = 1'b0;

    // Reset wins over load
    step();
    step();
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_expired", 32'(expired), 32'h0);
    rst = 1'b1; load = 1'b0;
    step();
    chk("idle_count", 32'(count), 32'h0);
    chk("idle_busy", 32'(busy), 32'h0);

    // One-shot from 5
    load = 1'b1; load_value = 8'd5; auto_reload = 1'b0; ena = 1'b1;
    step();
    load = 1'b0;
    chk("os_load_count", 32'(count), 32'd5);
    chk("os_load_busy", 32'(busy), 32'h1);
    chk("os_load_done", 32'(done), 32'h0);
    for (int i = 4; i >= 1; i--) begin
      step();
      chk("os_count", 32'(count), 32'(i));
      chk("os_done_low", 32'(done), 32'h0);
      chk("os_busy", 32'(busy), 32'h1);
    end
    step();
    chk("os_term_count", 32'(count), 32'h0);
    chk("os_term_done", 32'(done), 32'h1);
    chk("os_term_busy", 32'(busy), 32'h0);
    chk("os_term_expired", 32'(expired), 32'h1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("os_hold_expired", 32'(expired), 32'h1);
      chk("os_hold_done", 32'(done), 32'h0);
      chk("os_hold_count", 32'(count), 32'h0);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_exp_expired", 32'(expired), 32'h0);
    chk("stop_exp_busy", 32'(busy), 32'h0);

    // Periodic with reload 3
    load = 1'b1; load_value = 8'd3; auto_reload = 1'b1; ena = 1'b1;
    step();
    load = 1'b0;
    chk("per_load_count", 32'(count), 32'd3);
    pulses = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      exp_cnt = 8'(3 - (k % 3));
      chk("per_count", 32'(count), 32'(exp_cnt));
      chk("per_done", 32'(done), ((k % 3) == 0) ? 32'h1 : 32'h0);
      chk("per_expired", 32'(expired), 32'h0);
      if (done) pulses++;
    end
    chk("per_pulses", 32'(pulses), 32'd4);

    // Pause, then load beats stop
    load = 1'b1; load_value = 8'd4; auto_reload = 1'b0; ena = 1'b1;
    step();
    load = 1'b0;
    chk("pause_load", 32'(count), 32'd4);
    step();
    chk("pause_run1", 32'(count), 32'd3);
    ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("pause_hold", 32'(count), 32'd3);
      chk("pause_busy", 32'(busy), 32'h1);
      chk("pause_done", 32'(done), 32'h0);
    end
    load = 1'b1; load_value = 8'd9; stop = 1'b1;
    step();
    load = 1'b0; stop = 1'b0;
    chk("prio_count", 32'(count), 32'd9);
    chk("prio_busy", 32'(busy), 32'h1);
    stop = 1'b1; ena = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_busy", 32'(busy), 32'h0);
    chk("stop_count", 32'(count), 32'd9);
    step();
    chk("idle_no_dec", 32'(count), 32'd9);

    // Load 0 goes to IDLE without done
    load = 1'b1; load_value = 8'd0;
    step();
    load = 1'b0;
    chk("zero_count", 32'(count), 32'h0);
    chk("zero_busy", 32'(busy), 32'h0);
    chk("zero_done", 32'(done), 32'h0);
    step();
    chk("zero_done2", 32'(done), 32'h0);
    chk("zero_expired", 32'(expired), 32'h0);

    // Reload 1: done on every enabled cycle
    load = 1'b1; load_value = 8'd1; auto_reload = 1'b1; ena = 1'b1;
    step();
    load = 1'b0;
    chk("one_load_done", 32'(done), 32'h0);
    chk("one_load_busy", 32'(busy), 32'h1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("one_done", 32'(done), 32'h1);
      chk("one_count", 32'(count), 32'h1);
    end
    ena = 1'b0;
    step();
    chk("one_pause_done", 32'(done), 32'h0);

    // Max value: 255 enabled cycles to done
    load = 1'b1; load_value = 8'hFF; auto_reload = 1'b0; ena = 1'b1;
    step();
    load = 1'b0;
    chk("max_load", 32'(count), 32'hFF);
    n = 0;
    while (n < 300) begin
      step();
      n++;
      if (done) break;
    end
    chk("max_latency", 32'(n), 32'd255);
    chk("max_expired", 32'(expired), 32'h1);

    // Reset mid-count suppresses the pending done
    load = 1'b1; load_value = 8'd2; auto_reload = 1'b0; ena = 1'b1;
    step();
    load = 1'b0;
    step();
    chk("mid_count1", 32'(count), 32'h1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("mid_count", 32'(count), 32'h0);
    chk("mid_done", 32'(done), 32'h0);
    chk("mid_busy", 32'(busy), 32'h0);
    chk("mid_expired", 32'(expired), 32'h0);
    step();
    chk("mid_after_done", 32'(done), 32'h0);
    chk("mid_after_busy", 32'(busy), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
